// File: rtl/assoc_mem_topk.sv
// Associative memory: streams class HVs against a latched query and keeps the two nearest classes.
// Optional reject flag compiled in with `define ASSOC_MEM_REJECT_EN.
module assoc_mem_topk #(
  parameter int HVDimension = 512,
  parameter int ChunkWidth  = 128,
  parameter int DataWidth   = 8,
  localparam int ScoreWidth = $clog2(HVDimension + 1),
  localparam int NumChunks  = HVDimension / ChunkWidth
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic [HVDimension-1:0] query_hv_i,
  input  logic                   am_start_i,
  output logic                   am_busy_o,
  output logic                   am_stall_o,
  input  logic [ChunkWidth-1:0]  class_hv_i,
  input  logic                   class_hv_valid_i,
  output logic                   class_hv_ready_o,
  input  logic [DataWidth-1:0]   am_num_class_i,
  output logic [DataWidth-1:0]   predict_o,
  output logic [DataWidth-1:0]   predict_2nd_o,
  output logic [ScoreWidth-1:0]  score_o,
  output logic [ScoreWidth-1:0]  score_2nd_o,
  output logic [ScoreWidth-1:0]  margin_o,
  output logic                   predict_valid_o,
  input  logic                   predict_ready_i,
  output logic                   am_predict_valid_o,
  input  logic                   am_predict_valid_clr_i,
`ifdef ASSOC_MEM_REJECT_EN
  input  logic [ScoreWidth-1:0]  am_reject_thresh_i,
  output logic                   predict_reject_o,
`endif
  output logic [1:0]             am_state_o
);

  // Handshakes: a beat/result transfers on a rising edge where valid and ready are both high.
  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;
  localparam int BeatWidth = (NumChunks > 1) ? $clog2(NumChunks) : 1;
  localparam logic [ScoreWidth-1:0] ScoreMax = '1;
  localparam logic [BeatWidth-1:0]  LastBeat = BeatWidth'(NumChunks - 1);

  logic [1:0]             r_state;
  logic [HVDimension-1:0] r_query;
  logic [DataWidth-1:0]   r_num_class;
  logic [DataWidth-1:0]   r_class;
  logic [BeatWidth-1:0]   r_beat;
  logic [ScoreWidth-1:0]  r_acc;
  logic [ScoreWidth-1:0]  r_best;
  logic [ScoreWidth-1:0]  r_second;
  logic [ScoreWidth-1:0]  r_margin;
  logic [DataWidth-1:0]   r_best_idx;
  logic [DataWidth-1:0]   r_second_idx;
  logic                   r_valid;
  logic                   r_csr_valid;

  logic                   w_start_ok;
  logic                   w_last_beat;
  logic                   w_last_class;
  logic                   w_done_entry;
  logic [ChunkWidth-1:0]  w_query_chunk;
  logic [ChunkWidth-1:0]  w_diff;
  logic [ScoreWidth-1:0]  w_chunk_dist;
  logic [ScoreWidth-1:0]  w_dist;
  logic [ScoreWidth-1:0]  w_best_nxt;
  logic [ScoreWidth-1:0]  w_second_nxt;
  logic [DataWidth-1:0]   w_best_idx_nxt;
  logic [DataWidth-1:0]   w_second_idx_nxt;

  assign w_start_ok   = (r_state == ST_IDLE) && am_start_i;
  assign w_last_beat  = (r_state == ST_RUN) && class_hv_valid_i && (r_beat == LastBeat);
  assign w_last_class = (r_class == r_num_class - DataWidth'(1));
  assign w_done_entry = (w_start_ok && (am_num_class_i == '0)) || (w_last_beat && w_last_class);

  always_comb begin
    w_query_chunk = '0;
    for (int k = 0; k < NumChunks; k++) begin
      if (r_beat == BeatWidth'(k)) w_query_chunk = r_query[k*ChunkWidth +: ChunkWidth];
    end
  end

  assign w_diff = class_hv_i ^ w_query_chunk;

  always_comb begin
    w_chunk_dist = '0;
    for (int i = 0; i < ChunkWidth; i++) w_chunk_dist = w_chunk_dist + ScoreWidth'(w_diff[i]);
  end

  assign w_dist = r_acc + w_chunk_dist;

  // Strict less-than keeps the earlier (lower) class index on equal distances.
  always_comb begin
    w_best_nxt       = r_best;
    w_best_idx_nxt   = r_best_idx;
    w_second_nxt     = r_second;
    w_second_idx_nxt = r_second_idx;
    if (w_dist < r_best) begin
      w_second_nxt     = r_best;
      w_second_idx_nxt = r_best_idx;
      w_best_nxt       = w_dist;
      w_best_idx_nxt   = r_class;
    end else if (w_dist < r_second) begin
      w_second_nxt     = w_dist;
      w_second_idx_nxt = r_class;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state      <= ST_IDLE;
      r_query      <= '0;
      r_num_class  <= '0;
      r_class      <= '0;
      r_beat       <= '0;
      r_acc        <= '0;
      r_best       <= ScoreMax;
      r_second     <= ScoreMax;
      r_margin     <= '0;
      r_best_idx   <= '0;
      r_second_idx <= '0;
      r_valid      <= 1'b0;
      r_csr_valid  <= 1'b0;
    end else begin
      if (am_predict_valid_clr_i) r_csr_valid <= 1'b0;
      if (w_done_entry)           r_csr_valid <= 1'b1;
      case (r_state)
        ST_IDLE: begin
          if (am_start_i) begin
            r_query      <= query_hv_i;
            r_num_class  <= am_num_class_i;
            r_class      <= '0;
            r_beat       <= '0;
            r_acc        <= '0;
            r_best       <= ScoreMax;
            r_second     <= ScoreMax;
            r_margin     <= '0;
            r_best_idx   <= '0;
            r_second_idx <= '0;
            if (am_num_class_i == '0) begin
              r_state <= ST_DONE;
              r_valid <= 1'b1;
            end else begin
              r_state <= ST_RUN;
            end
          end
        end
        ST_RUN: begin
          if (class_hv_valid_i) begin
            if (r_beat != LastBeat) begin
              r_acc  <= w_dist;
              r_beat <= r_beat + BeatWidth'(1);
            end else begin
              r_acc        <= '0;
              r_beat       <= '0;
              r_class      <= r_class + DataWidth'(1);
              r_best       <= w_best_nxt;
              r_best_idx   <= w_best_idx_nxt;
              r_second     <= w_second_nxt;
              r_second_idx <= w_second_idx_nxt;
              r_margin     <= w_second_nxt - w_best_nxt;
              if (w_last_class) begin
                r_state <= ST_DONE;
                r_valid <= 1'b1;
              end
            end
          end
        end
        ST_DONE: begin
          if (predict_ready_i) begin
            r_state <= ST_IDLE;
            r_valid <= 1'b0;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

`ifdef ASSOC_MEM_REJECT_EN
  logic r_reject;
  // An empty class list finishes with the all-ones score, so it is judged against that.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_reject <= 1'b0;
    end else if (w_done_entry) begin
      r_reject <= (w_start_ok ? ScoreMax : w_best_nxt) > am_reject_thresh_i;
    end else if (w_start_ok) begin
      r_reject <= 1'b0;
    end
  end
  assign predict_reject_o = r_reject;
`endif

  assign am_busy_o          = (r_state != ST_IDLE);
  assign am_stall_o         = am_start_i && (r_state != ST_IDLE);
  assign class_hv_ready_o   = (r_state == ST_RUN);
  assign predict_o          = r_best_idx;
  assign predict_2nd_o      = r_second_idx;
  assign score_o            = r_best;
  assign score_2nd_o        = r_second;
  assign margin_o           = r_margin;
  assign predict_valid_o    = r_valid;
  assign am_predict_valid_o = r_csr_valid;
  assign am_state_o         = r_state;

endmodule

// File: tb/tb_assoc_mem_topk.sv
// Bench for assoc_mem_topk: random class streams checked against a full-vector Hamming top-2 model.
// Build with +define+ASSOC_MEM_REJECT_EN to also cover the reject flag.
module tb_assoc_mem_topk;
  localparam int HVD = 512;
  localparam int CW  = 128;
  localparam int DW  = 8;
  localparam int SW  = $clog2(HVD + 1);
  localparam int NC  = HVD / CW;
  localparam int ONES = (1 << SW) - 1;

  logic           clk = 1'b0;
  logic           rst_i;
  logic [HVD-1:0] query_hv_i;
  logic           am_start_i;
  logic           am_busy_o;
  logic           am_stall_o;
  logic [CW-1:0]  class_hv_i;
  logic           class_hv_valid_i;
  logic           class_hv_ready_o;
  logic [DW-1:0]  am_num_class_i;
  logic [DW-1:0]  predict_o;
  logic [DW-1:0]  predict_2nd_o;
  logic [SW-1:0]  score_o;
  logic [SW-1:0]  score_2nd_o;
  logic [SW-1:0]  margin_o;
  logic           predict_valid_o;
  logic           predict_ready_i;
  logic           am_predict_valid_o;
  logic           am_predict_valid_clr_i;
  logic [1:0]     am_state_o;
`ifdef ASSOC_MEM_REJECT_EN
  logic [SW-1:0]  am_reject_thresh_i;
  logic           predict_reject_o;
`endif

  int n_total = 0;
  int n_bad   = 0;
  logic [HVD-1:0] cls_q[$];

  // clock / reset
  always #5 clk = ~clk;

  assoc_mem_topk #(.HVDimension(HVD), .ChunkWidth(CW), .DataWidth(DW)) dut (
    .clk_i(clk), .rst_i(rst_i), .query_hv_i(query_hv_i), .am_start_i(am_start_i),
    .am_busy_o(am_busy_o), .am_stall_o(am_stall_o), .class_hv_i(class_hv_i),
    .class_hv_valid_i(class_hv_valid_i), .class_hv_ready_o(class_hv_ready_o),
    .am_num_class_i(am_num_class_i), .predict_o(predict_o), .predict_2nd_o(predict_2nd_o),
    .score_o(score_o), .score_2nd_o(score_2nd_o), .margin_o(margin_o),
    .predict_valid_o(predict_valid_o), .predict_ready_i(predict_ready_i),
    .am_predict_valid_o(am_predict_valid_o), .am_predict_valid_clr_i(am_predict_valid_clr_i),
`ifdef ASSOC_MEM_REJECT_EN
    .am_reject_thresh_i(am_reject_thresh_i), .predict_reject_o(predict_reject_o),
`endif
    .am_state_o(am_state_o)
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0d exp=%0d at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [HVD-1:0] rand_hv();
    logic [HVD-1:0] v;
    for (int i = 0; i < HVD / 32; i++) v[i*32 +: 32] = $urandom;
    return v;
  endfunction

  function automatic logic [HVD-1:0] flip_n(input logic [HVD-1:0] q, input int n);
    logic [HVD-1:0] m;
    int p;
    int cnt;
    m = '0;
    cnt = 0;
    while (cnt < n) begin
      p = $urandom_range(HVD - 1, 0);
      if (!m[p]) begin
        m[p] = 1'b1;
        cnt++;
      end
    end
    return q ^ m;
  endfunction

  // Reference: nearest class = first argmin of full-vector distance, runner-up = first argmin of the rest.
  task automatic ref_topk(input logic [HVD-1:0] q, input int n,
                          output int b_i, output int b_s, output int s_i, output int s_s);
    int d;
    b_i = 0; b_s = ONES; s_i = 0; s_s = ONES;
    for (int i = 0; i < n; i++) begin
      d = $countones(q ^ cls_q[i]);
      if (d < b_s) begin b_s = d; b_i = i; end
    end
    for (int i = 0; i < n; i++) begin
      d = $countones(q ^ cls_q[i]);
      if (i != b_i && d < s_s) begin s_s = d; s_i = i; end
    end
  endtask

  task automatic do_reset();
    rst_i = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst_i = 1'b0;
  endtask

  task automatic check_reset_values(input string tag);
    chk({tag, "_busy"},   am_busy_o, 0);
    chk({tag, "_valid"},  predict_valid_o, 0);
    chk({tag, "_csr"},    am_predict_valid_o, 0);
    chk({tag, "_pred"},   predict_o, 0);
    chk({tag, "_pred2"},  predict_2nd_o, 0);
    chk({tag, "_score"},  score_o, ONES);
    chk({tag, "_score2"}, score_2nd_o, ONES);
    chk({tag, "_margin"}, margin_o, 0);
    chk({tag, "_ready"},  class_hv_ready_o, 0);
`ifdef ASSOC_MEM_REJECT_EN
    chk({tag, "_reject"}, predict_reject_o, 0);
`endif
  endtask

  // driver: one full job from start to result handoff
  task automatic run_job(input string tag, input logic [HVD-1:0] q, input int n, input int gap_pct,
                         input bit mid_start, input int hold, input bit clr_at_entry);
    int eb_i, eb_s, es_i, es_s, waited;
    logic [HVD-1:0] chv;
    ref_topk(q, n, eb_i, eb_s, es_i, es_s);
    @(posedge clk); #1;
    query_hv_i = q;
    am_num_class_i = DW'(n);
    am_start_i = 1'b1;
    predict_ready_i = (hold == 0);
    am_predict_valid_clr_i = (n == 0) && clr_at_entry;
    #1 chk({tag, "_stall_idle"}, am_stall_o, 0);
    @(posedge clk); #1;
    am_start_i = 1'b0;
    am_predict_valid_clr_i = 1'b0;
    query_hv_i = rand_hv();
    chk({tag, "_busy"}, am_busy_o, 1);
    for (int c = 0; c < n; c++) begin
      for (int b = 0; b < NC; b++) begin
        for (int g = 0; g < 3 && $urandom_range(99, 0) < gap_pct; g++) begin
          class_hv_valid_i = 1'b0;
          class_hv_i = rand_hv()[CW-1:0];
          if (mid_start && $urandom_range(1, 0) == 1) begin
            am_start_i = 1'b1;
            query_hv_i = rand_hv();
            #1 chk({tag, "_stall_run"}, am_stall_o, 1);
          end
          @(posedge clk); #1;
          am_start_i = 1'b0;
        end
        chv = cls_q[c];
        class_hv_i = chv[b*CW +: CW];
        class_hv_valid_i = 1'b1;
        if (c == n - 1 && b == NC - 1) am_predict_valid_clr_i = clr_at_entry;
        #1 chk({tag, "_ready_o"}, class_hv_ready_o, 1);
        @(posedge clk); #1;
        class_hv_valid_i = 1'b0;
        am_predict_valid_clr_i = 1'b0;
      end
    end
    #1 chk({tag, "_valid_latency"}, predict_valid_o, 1);
    waited = 0;
    while (!predict_valid_o && waited < 40) begin
      @(posedge clk); #1;
      waited++;
    end
    if (!predict_valid_o) begin
      chk({tag, "_valid_timeout"}, predict_valid_o, 1);
      do_reset();
      return;
    end
    chk({tag, "_pred"},   predict_o, eb_i);
    chk({tag, "_score"},  score_o, eb_s);
    chk({tag, "_pred2"},  predict_2nd_o, es_i);
    chk({tag, "_score2"}, score_2nd_o, es_s);
    chk({tag, "_margin"}, margin_o, es_s - eb_s);
    chk({tag, "_csr_set"}, am_predict_valid_o, 1);
`ifdef ASSOC_MEM_REJECT_EN
    chk({tag, "_reject"}, predict_reject_o, eb_s > int'(am_reject_thresh_i));
`endif
    for (int k = 0; k < hold; k++) begin
      am_start_i = (k % 2 == 0);
      #1 chk({tag, "_stall_done"}, am_stall_o, am_start_i);
      chk({tag, "_valid_hold"}, predict_valid_o, 1);
      @(posedge clk); #1;
      am_start_i = 1'b0;
    end
    predict_ready_i = 1'b1;
    @(posedge clk); #1;
    predict_ready_i = 1'b0;
    chk({tag, "_valid_drop"}, predict_valid_o, 0);
    chk({tag, "_idle"}, am_busy_o, 0);
    chk({tag, "_pred_held"}, predict_o, eb_i);
    chk({tag, "_score_held"}, score_o, eb_s);
    chk({tag, "_csr_sticky"}, am_predict_valid_o, 1);
    am_predict_valid_clr_i = 1'b1;
    @(posedge clk); #1;
    am_predict_valid_clr_i = 1'b0;
    chk({tag, "_csr_clr"}, am_predict_valid_o, 0);
  endtask

  initial begin
    logic [HVD-1:0] q;
    int n, kind;
    rst_i = 1'b1;
    query_hv_i = '0;
    am_start_i = 1'b0;
    class_hv_i = '0;
    class_hv_valid_i = 1'b0;
    am_num_class_i = '0;
    predict_ready_i = 1'b0;
    am_predict_valid_clr_i = 1'b0;
`ifdef ASSOC_MEM_REJECT_EN
    am_reject_thresh_i = SW'(100);
`endif
    do_reset();
    #1 check_reset_values("rst");

    // four classes at distances 10,20,30,40
    q = rand_hv();
    cls_q.delete();
    for (int c = 0; c < 4; c++) cls_q.push_back(flip_n(q, 10 * (c + 1)));
    run_job("t1", q, 4, 0, 1'b0, 0, 1'b0);

    // tie on 30 keeps index 0 as runner-up
    q = rand_hv();
    cls_q.delete();
    cls_q.push_back(flip_n(q, 30));
    cls_q.push_back(flip_n(q, 30));
    cls_q.push_back(flip_n(q, 5));
    run_job("t2", q, 3, 0, 1'b0, 1, 1'b0);

    run_job("t3_empty", rand_hv(), 0, 0, 1'b0, 2, 1'b0);

    q = rand_hv();
    cls_q.delete();
    for (int c = 0; c < 5; c++) cls_q.push_back(flip_n(q, $urandom_range(80, 0)));
    run_job("t4_gaps", q, 5, 40, 1'b1, 0, 1'b0);

    q = rand_hv();
    cls_q.delete();
    for (int c = 0; c < 3; c++) cls_q.push_back(flip_n(q, $urandom_range(60, 1)));
    run_job("t5_hold", q, 3, 10, 1'b0, 5, 1'b1);

    q = rand_hv();
    cls_q.delete();
    cls_q.push_back(flip_n(q, 17));
    run_job("one_class", q, 1, 20, 1'b0, 1, 1'b0);

    for (int j = 0; j < 8; j++) begin
      q = rand_hv();
      n = $urandom_range(7, 1);
      cls_q.delete();
      for (int c = 0; c < n; c++) begin
        kind = $urandom_range(2, 0);
        if (kind == 0) cls_q.push_back(rand_hv());
        else if (kind == 1 || c == 0) cls_q.push_back(flip_n(q, $urandom_range(60, 0)));
        else cls_q.push_back(cls_q[$urandom_range(c - 1, 0)]);
      end
`ifdef ASSOC_MEM_REJECT_EN
      am_reject_thresh_i = SW'($urandom_range(300, 0));
`endif
      run_job("rnd", q, n, $urandom_range(50, 0), 1'b1, $urandom_range(3, 0), 1'($urandom_range(1, 0)));
    end

`ifdef ASSOC_MEM_REJECT_EN
    q = rand_hv();
    cls_q.delete();
    for (int c = 0; c < 4; c++) cls_q.push_back(flip_n(q, 10 * (c + 1)));
    am_reject_thresh_i = SW'(8);
    run_job("t6_thr8", q, 4, 0, 1'b0, 0, 1'b0);
    am_reject_thresh_i = SW'(10);
    run_job("t6_thr10", q, 4, 0, 1'b0, 0, 1'b0);
`endif

    // reset in the middle of a run: everything back to reset values, no result appears
    q = rand_hv();
    cls_q.delete();
    for (int c = 0; c < 4; c++) cls_q.push_back(flip_n(q, 5 * (c + 1)));
    @(posedge clk); #1;
    query_hv_i = q;
    am_num_class_i = DW'(4);
    am_start_i = 1'b1;
    predict_ready_i = 1'b0;
    @(posedge clk); #1;
    am_start_i = 1'b0;
    for (int b = 0; b < 5; b++) begin
      q = cls_q[b / NC];
      class_hv_i = q[(b % NC)*CW +: CW];
      class_hv_valid_i = 1'b1;
      @(posedge clk); #1;
    end
    class_hv_valid_i = 1'b0;
    chk("mid_busy", am_busy_o, 1);
    rst_i = 1'b1;
    @(posedge clk); #1;
    rst_i = 1'b0;
    check_reset_values("mid_rst");
    for (int k = 0; k < 10; k++) begin
      @(posedge clk); #1;
      chk("mid_no_valid", predict_valid_o, 0);
    end

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog expired total=%0d bad=%0d", n_total, n_bad);
    $fatal(1, "watchdog");
  end

endmodule
